// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore sequencing FSM plus combinational instruction
// decode, with optional memory-ready wait states and an extended ALU operation set.
module arm_mc_controller #(
  parameter int unsigned EXT_ALU  = 0,
  parameter int unsigned WAIT_MEM = 0,
  parameter int unsigned ACW      = (EXT_ALU != 0) ? 3 : 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     Op,
  input  logic [5:0]     Funct,
  input  logic [3:0]     Rd,
  input  logic           MemReady,
  output logic           IRWrite,
  output logic           NextPC,
  output logic           Branch,
  output logic           PCS,
  output logic           RegW,
  output logic           MemW,
  output logic           AdrSrc,
  output logic [1:0]     ResultSrc,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ImmSrc,
  output logic [1:0]     RegSrc,
  output logic [ACW-1:0] ALUControl,
  output logic [1:0]     FlagW,
  output logic [3:0]     State
);
  localparam int unsigned SW  = 4;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] ALU_ADD = 3'd0;
  localparam logic [OPW-1:0] ALU_SUB = 3'd1;
  localparam logic [OPW-1:0] ALU_AND = 3'd2;
  localparam logic [OPW-1:0] ALU_ORR = 3'd3;
  localparam logic [OPW-1:0] ALU_EOR = 3'd4;

  typedef enum logic [SW-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t         state_q, state_d;
  logic           ready;
  logic           alu_en;
  logic [OPW-1:0] alu_op;

  assign ready = (WAIT_MEM != 0) ? MemReady : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore control; enables are forced low while reset is held
  always_comb begin
    state_d   = state_q;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    Branch    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    alu_en    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = ready;
        NextPC    = ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_en  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_en  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegW    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      Branch  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      alu_en  = 1'b0;
    end
  end

  // Data-processing operation select from Funct[4:1]; unknown codes fall back to ADD
  always_comb begin
    alu_op = ALU_ADD;
    case (Funct[4:1])
      4'b0100: alu_op = ALU_ADD;
      4'b0010: alu_op = ALU_SUB;
      4'b0000: alu_op = ALU_AND;
      4'b1100: alu_op = ALU_ORR;
      4'b0001: if (EXT_ALU != 0) alu_op = ALU_EOR;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign ALUControl = alu_en ? ACW'(alu_op) : '0;
  assign FlagW      = alu_en ? {Funct[0], Funct[0] & ((alu_op == ALU_ADD) | (alu_op == ALU_SUB))}
                             : 2'b00;
  assign PCS        = ((Rd == 4'hF) & RegW) | Branch;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign State      = state_q;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: directed vector table, reset corner sequences and a
// randomized instruction stream checked against an instruction-level step model.
module tb_arm_mc_controller;
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4;
  localparam int MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // Instance a: EXT_ALU=1, WAIT_MEM=1; instance b: EXT_ALU=0, WAIT_MEM=0
  logic [1:0] op_a, op_b;
  logic [5:0] funct_a, funct_b;
  logic [3:0] rd_a, rd_b;
  logic       mr_a, mr_b;
  logic       irw_a, npc_a, br_a, pcs_a, regw_a, memw_a, adr_a, srca_a;
  logic       irw_b, npc_b, br_b, pcs_b, regw_b, memw_b, adr_b, srca_b;
  logic [1:0] res_a, srcb_a, imm_a, regsrc_a, flagw_a;
  logic [1:0] res_b, srcb_b, imm_b, regsrc_b, flagw_b;
  logic [2:0] aluc_a;
  logic [1:0] aluc_b;
  logic [3:0] st_a, st_b;

  arm_mc_controller #(.EXT_ALU(1), .WAIT_MEM(1)) dut_a (
    .clk(clk), .reset(reset), .Op(op_a), .Funct(funct_a), .Rd(rd_a), .MemReady(mr_a),
    .IRWrite(irw_a), .NextPC(npc_a), .Branch(br_a), .PCS(pcs_a), .RegW(regw_a), .MemW(memw_a),
    .AdrSrc(adr_a), .ResultSrc(res_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .ImmSrc(imm_a),
    .RegSrc(regsrc_a), .ALUControl(aluc_a), .FlagW(flagw_a), .State(st_a));

  arm_mc_controller #(.EXT_ALU(0), .WAIT_MEM(0)) dut_b (
    .clk(clk), .reset(reset), .Op(op_b), .Funct(funct_b), .Rd(rd_b), .MemReady(mr_b),
    .IRWrite(irw_b), .NextPC(npc_b), .Branch(br_b), .PCS(pcs_b), .RegW(regw_b), .MemW(memw_b),
    .AdrSrc(adr_b), .ResultSrc(res_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .ImmSrc(imm_b),
    .RegSrc(regsrc_b), .ALUControl(aluc_b), .FlagW(flagw_b), .State(st_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- directed vector table (instance a) ----------------
  typedef struct packed {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mr;
    logic [3:0] st;
    logic [5:0] en;     // {IRWrite, RegW, MemW, Branch, PCS, AdrSrc}
    logic [1:0] res;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] flagw;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(logic [1:0] op, logic [5:0] f, logic [3:0] rd, logic mr,
                              logic [3:0] st, logic [5:0] en, logic [1:0] res,
                              logic [1:0] srcb, logic [2:0] aluc, logic [1:0] flagw);
    tbl.push_back('{op, f, rd, mr, st, en, res, srcb, aluc, flagw});
  endfunction

  function automatic void fd(logic [1:0] op, logic [5:0] f, logic [3:0] rd);
    row(op, f, rd, 1'b1, 4'd0, 6'b100000, 2'b10, 2'b10, 3'd0, 2'b00);
    row(op, f, rd, 1'b1, 4'd1, 6'b000000, 2'b10, 2'b10, 3'd0, 2'b00);
  endfunction

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic irw, npc, br, pcs, regw, memw, adr;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb, imm, regsrc;
    logic [2:0] aluc;
    logic [1:0] flagw;
    logic [3:0] st;
  } out_t;

  logic [1:0] m_op[2];
  logic [5:0] m_f[2];
  logic [3:0] m_rd[2];
  int         m_seq[2][5];
  int         m_len[2];
  int         m_idx[2];
  bit         m_new[2];

  function automatic void push(int d, int s);
    m_seq[d][m_len[d]] = s;
    m_len[d]++;
  endfunction

  // Pick a random instruction and lay out the step list it walks through
  function automatic void new_instr(int d);
    m_op[d]  = 2'($urandom_range(0, 3));
    m_f[d]   = 6'($urandom);
    m_rd[d]  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    m_len[d] = 0;
    m_idx[d] = 0;
    push(d, FETCH);
    push(d, DECODE);
    case (m_op[d])
      2'b00: begin push(d, m_f[d][5] ? EXECI : EXECR); push(d, ALUWB); end
      2'b01: begin
        push(d, MEMADR);
        if (m_f[d][0]) begin push(d, MEMREAD); push(d, MEMWB); end
        else push(d, MEMWRITE);
      end
      2'b10: push(d, BRANCH);
      default: ;
    endcase
  endfunction

  function automatic void advance(int d, logic rdy);
    int s = m_seq[d][m_idx[d]];
    if ((s == FETCH || s == MEMREAD || s == MEMWRITE) && !rdy) return;
    m_idx[d]++;
    if (m_idx[d] == m_len[d]) m_new[d] = 1'b1;
  endfunction

  function automatic logic [2:0] alu_of(logic [3:0] f, bit ext);
    if (f == 4'b0010) return 3'd1;
    if (f == 4'b0000) return 3'd2;
    if (f == 4'b1100) return 3'd3;
    if (ext && f == 4'b0001) return 3'd4;
    return 3'd0;
  endfunction

  function automatic out_t model_out(int s, logic [1:0] op, logic [5:0] f, logic [3:0] rd,
                                     logic rdy, bit ext);
    out_t o = '0;
    o.st     = 4'(s);
    o.imm    = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    if (s == FETCH || s == DECODE) begin
      o.srca = 1'b1; o.srcb = 2'b10; o.res = 2'b10;
    end
    if (s == FETCH) begin o.irw = rdy; o.npc = rdy; end
    if (s == MEMADR || s == EXECI || s == BRANCH) o.srcb = 2'b01;
    if (s == MEMREAD || s == MEMWRITE) o.adr = 1'b1;
    if (s == MEMWRITE) o.memw = 1'b1;
    if (s == MEMWB) o.res = 2'b01;
    if (s == MEMWB || s == ALUWB) o.regw = 1'b1;
    if (s == BRANCH) begin o.br = 1'b1; o.res = 2'b10; end
    if (s == EXECR || s == EXECI) begin
      o.aluc  = alu_of(f[4:1], ext);
      o.flagw = {f[0], f[0] && (o.aluc == 3'd0 || o.aluc == 3'd1)};
    end
    o.pcs = (o.regw && rd == 4'hF) || o.br;
    return o;
  endfunction

  function automatic out_t snap_a();
    return {irw_a, npc_a, br_a, pcs_a, regw_a, memw_a, adr_a, res_a, srca_a, srcb_a,
            imm_a, regsrc_a, aluc_a, flagw_a, st_a};
  endfunction

  function automatic out_t snap_b();
    return {irw_b, npc_b, br_b, pcs_b, regw_b, memw_b, adr_b, res_b, srca_b, srcb_b,
            imm_b, regsrc_b, 3'(aluc_b), flagw_b, st_b};
  endfunction

  initial begin
    op_a = 2'b11; funct_a = '0; rd_a = '0; mr_a = 1'b1;
    op_b = 2'b11; funct_b = '0; rd_b = '0; mr_b = 1'b1;

    // Reset state of both instances, MemReady high
    @(negedge clk); #1;
    check("rst_a", 64'({st_a, irw_a, npc_a, regw_a, memw_a, br_a, pcs_a, flagw_a, adr_a, srca_a, srcb_a, res_a}),
          64'({4'd0, 8'h00, 1'b0, 1'b1, 2'b10, 2'b10}));
    check("rst_b", 64'({st_b, irw_b, npc_b, regw_b, memw_b, br_b, pcs_b, flagw_b}), 64'(0));

    // Instance b: no wait states, EOR code decodes as ADD with S set
    @(negedge clk);
    reset = 1'b0;
    op_b = 2'b00; funct_b = 6'b000011; rd_b = 4'd1; mr_b = 1'b0;
    #1 check("b_fetch_noready", 64'({st_b, irw_b, npc_b}), 64'({4'd0, 2'b11}));
    @(posedge clk); @(negedge clk); #1 check("b_decode", 64'(st_b), 64'(1));
    @(posedge clk); @(negedge clk); #1
    check("b_exec_eor", 64'({st_b, aluc_b, flagw_b}), 64'({4'd6, 2'b00, 2'b11}));
    @(posedge clk); @(negedge clk); #1
    check("b_aluwb", 64'({st_b, regw_b, pcs_b}), 64'({4'd8, 2'b10}));
    @(posedge clk);
    op_b = 2'b11; mr_b = 1'b1;

    // Directed vectors for instance a, starting in FETCH
    fd(2'b00, 6'b001000, 4'd1);                                                        // ADD
    row(2'b00, 6'b001000, 4'd1, 1'b1, 4'd6, 6'b000000, 2'b00, 2'b00, 3'd0, 2'b00);
    row(2'b00, 6'b001000, 4'd1, 1'b1, 4'd8, 6'b010000, 2'b00, 2'b00, 3'd0, 2'b00);
    fd(2'b00, 6'b000101, 4'd2);                                                        // SUBS
    row(2'b00, 6'b000101, 4'd2, 1'b1, 4'd6, 6'b000000, 2'b00, 2'b00, 3'd1, 2'b11);
    row(2'b00, 6'b000101, 4'd2, 1'b1, 4'd8, 6'b010000, 2'b00, 2'b00, 3'd0, 2'b00);
    fd(2'b00, 6'b111001, 4'd3);                                                        // ORRS imm
    row(2'b00, 6'b111001, 4'd3, 1'b1, 4'd7, 6'b000000, 2'b00, 2'b01, 3'd3, 2'b10);
    row(2'b00, 6'b111001, 4'd3, 1'b1, 4'd8, 6'b010000, 2'b00, 2'b00, 3'd0, 2'b00);
    fd(2'b00, 6'b100010, 4'd4);                                                        // EOR imm
    row(2'b00, 6'b100010, 4'd4, 1'b1, 4'd7, 6'b000000, 2'b00, 2'b01, 3'd4, 2'b00);
    row(2'b00, 6'b100010, 4'd4, 1'b1, 4'd8, 6'b010000, 2'b00, 2'b00, 3'd0, 2'b00);
    row(2'b01, 6'b011001, 4'd5, 1'b0, 4'd0, 6'b000000, 2'b10, 2'b10, 3'd0, 2'b00);    // LDR, waits
    fd(2'b01, 6'b011001, 4'd5);
    row(2'b01, 6'b011001, 4'd5, 1'b1, 4'd2, 6'b000000, 2'b00, 2'b01, 3'd0, 2'b00);
    row(2'b01, 6'b011001, 4'd5, 1'b0, 4'd3, 6'b000001, 2'b00, 2'b00, 3'd0, 2'b00);
    row(2'b01, 6'b011001, 4'd5, 1'b0, 4'd3, 6'b000001, 2'b00, 2'b00, 3'd0, 2'b00);
    row(2'b01, 6'b011001, 4'd5, 1'b1, 4'd3, 6'b000001, 2'b00, 2'b00, 3'd0, 2'b00);
    row(2'b01, 6'b011001, 4'd5, 1'b1, 4'd4, 6'b010000, 2'b01, 2'b00, 3'd0, 2'b00);
    fd(2'b01, 6'b011000, 4'd6);                                                        // STR, one wait
    row(2'b01, 6'b011000, 4'd6, 1'b1, 4'd2, 6'b000000, 2'b00, 2'b01, 3'd0, 2'b00);
    row(2'b01, 6'b011000, 4'd6, 1'b0, 4'd5, 6'b001001, 2'b00, 2'b00, 3'd0, 2'b00);
    row(2'b01, 6'b011000, 4'd6, 1'b1, 4'd5, 6'b001001, 2'b00, 2'b00, 3'd0, 2'b00);
    fd(2'b10, 6'b101000, 4'd0);                                                        // B
    row(2'b10, 6'b101000, 4'd0, 1'b1, 4'd9, 6'b000110, 2'b10, 2'b01, 3'd0, 2'b00);
    fd(2'b01, 6'b011001, 4'd15);                                                       // LDR PC
    row(2'b01, 6'b011001, 4'd15, 1'b1, 4'd2, 6'b000000, 2'b00, 2'b01, 3'd0, 2'b00);
    row(2'b01, 6'b011001, 4'd15, 1'b1, 4'd3, 6'b000001, 2'b00, 2'b00, 3'd0, 2'b00);
    row(2'b01, 6'b011001, 4'd15, 1'b1, 4'd4, 6'b010010, 2'b01, 2'b00, 3'd0, 2'b00);
    fd(2'b11, 6'b000000, 4'd15);                                                       // undefined: NOP

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      op_a = tbl[i].op; funct_a = tbl[i].funct; rd_a = tbl[i].rd; mr_a = tbl[i].mr;
      #1;
      check($sformatf("vec%0d", i),
            64'({st_a, irw_a, regw_a, memw_a, br_a, pcs_a, adr_a, res_a, srcb_a, aluc_a, flagw_a}),
            64'({tbl[i].st, tbl[i].en, tbl[i].res, tbl[i].srcb, tbl[i].aluc, tbl[i].flagw}));
      @(posedge clk);
    end

    // Reset asserted in the middle of a stalled MEMWRITE
    @(negedge clk);
    op_a = 2'b01; funct_a = 6'b011000; rd_a = 4'd7; mr_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mr_a = 1'b0;
    #1 check("memwrite_wait", 64'({st_a, memw_a, adr_a}), 64'({4'd5, 2'b11}));
    #2 reset = 1'b1; mr_a = 1'b1;
    #1 check("async_rst", 64'({st_a, memw_a, irw_a, npc_a, regw_a, adr_a, srca_a, srcb_a, res_a}),
             64'({4'd0, 5'b00000, 1'b1, 2'b10, 2'b10}));
    @(posedge clk); #1
    check("rst_held", 64'({st_a, irw_a, npc_a, memw_a}), 64'({4'd0, 3'b000}));
    @(negedge clk);
    reset = 1'b0; op_a = 2'b11; funct_a = 6'b111111; rd_a = 4'hF;
    #1 check("post_rst_fetch", 64'({st_a, irw_a, npc_a}), 64'({4'd0, 2'b11}));
    @(posedge clk); @(negedge clk); #1
    check("nop_decode", 64'({st_a, regw_a, memw_a, irw_a, br_a, pcs_a}), 64'({4'd1, 5'b00000}));
    @(posedge clk); @(negedge clk); #1
    check("nop_back", 64'(st_a), 64'(0));

    // Randomized instruction streams on both instances against the step model
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_new[0] = 1'b1; m_new[1] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (m_new[d]) begin new_instr(d); m_new[d] = 1'b0; end
      op_a = m_op[0]; funct_a = m_f[0]; rd_a = m_rd[0]; mr_a = ($urandom_range(0, 3) != 0);
      op_b = m_op[1]; funct_b = m_f[1]; rd_b = m_rd[1]; mr_b = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("rand_a c%0d", c), 64'(snap_a()),
            64'(model_out(m_seq[0][m_idx[0]], m_op[0], m_f[0], m_rd[0], mr_a, 1'b1)));
      check($sformatf("rand_b c%0d", c), 64'(snap_b()),
            64'(model_out(m_seq[1][m_idx[1]], m_op[1], m_f[1], m_rd[1], 1'b1, 1'b0)));
      @(posedge clk);
      advance(0, mr_a);
      advance(1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
